// File: rtl/sm2_pkg.sv
// Shared constants and enums for the SM2 modular reduction engine.
package sm2_pkg;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [256:0] SM2_2P = {SM2_P, 1'b0};

  typedef enum logic [1:0] {
    MODE_REDUCE = 2'b00,
    MODE_ADD    = 2'b01,
    MODE_SUB    = 2'b10
  } sm2_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FOLD,
    ST_FINAL,
    ST_DONE
  } sm2_state_e;

  // Accumulator must hold a[255:0] + 2p - b, which needs 258 bits.
  function automatic int acc_w(input int in_w);
    return (in_w < 258) ? 258 : in_w;
  endfunction

endpackage

// File: rtl/sm2_fold_unit.sv
// One combinational fold step: acc = H*2^256 + L  ->  L + H*(2^224 + 2^96 - 2^64 + 1).
module sm2_fold_unit
  import sm2_pkg::*;
#(
  parameter int IN_W = 512,
  localparam int AW  = acc_w(IN_W)
) (
  input  logic [AW-1:0] acc_in,
  output logic [AW-1:0] acc_out,
  output logic          h_zero
);

  localparam int HW = AW - 256;

  logic [AW-1:0] hx, lx;

  assign hx     = {{256{1'b0}}, acc_in[AW-1:256]};
  assign lx     = {{HW{1'b0}}, acc_in[255:0]};
  assign h_zero = (acc_in[AW-1:256] == '0);

  // Never negative since H<<96 >= H<<64, so modular AW-bit arithmetic is exact.
  assign acc_out = lx + (hx << 224) + (hx << 96) - (hx << 64) + hx;

endmodule

// File: rtl/sm2_mod_reduce_seq.sv
// Handshaked SM2 reduce / modadd / modsub engine, one fold per cycle.
// Define SM2_RED_CONST_TIME_EN for a fixed MAX_FOLDS fold count and branch-free final subtract.
module sm2_mod_reduce_seq
  import sm2_pkg::*;
#(
  parameter int IN_W      = 512,
  parameter int MAX_FOLDS = 12,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IN_W-1:0]  in_a,
  input  logic [255:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_r,
  output logic             out_err,
  output logic [CNT_W-1:0] fold_cnt
);

  localparam int               AW      = acc_w(IN_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FOLDS);

  sm2_state_e       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d, acc_load, acc_fold;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, vld_q, vld_d, rdy_q, rdy_d, h_zero;
  logic [255:0]     r_q, r_d, r_fin;

  sm2_fold_unit #(.IN_W(IN_W)) u_fold (
    .acc_in  (acc_q),
    .acc_out (acc_fold),
    .h_zero  (h_zero)
  );

  always_comb begin
    case (sm2_mode_e'(in_mode))
      MODE_ADD: acc_load = AW'(in_a[255:0]) + AW'(in_b);
      MODE_SUB: acc_load = AW'(in_a[255:0]) + AW'(SM2_2P) - AW'(in_b);
      default:  acc_load = AW'(in_a);
    endcase
  end

`ifdef SM2_RED_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
  logic [256:0] diff;
  assign diff  = {1'b0, acc_q[255:0]} - {1'b0, SM2_P};
  assign r_fin = diff[256] ? acc_q[255:0] : diff[255:0];
`else
  localparam bit CONST_TIME = 1'b0;
  assign r_fin = (acc_q[255:0] >= SM2_P) ? (acc_q[255:0] - SM2_P) : acc_q[255:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vld_d   = vld_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        acc_d   = acc_load;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_FOLD;
      end
      ST_FOLD: begin
        // Bound check runs one cycle after the last permitted fold.
        if (cnt_q == CNT_MAX) begin
          err_d   = !h_zero;
          state_d = ST_FINAL;
        end else if (CONST_TIME || !h_zero) begin
          acc_d = acc_fold;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        r_d     = r_fin;
        vld_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_r     = r_q;
  assign out_err   = err_q;
  assign fold_cnt  = cnt_q;

endmodule

// File: tb/tb_sm2_mod_reduce_seq.sv
// Directed + random bench for sm2_mod_reduce_seq against a plain "x mod p" reference.
module tb_sm2_mod_reduce_seq;

  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] R256 =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
  localparam int MAXF = 12;
`ifdef SM2_RED_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]   in_mode;
  logic [511:0] in_a;
  logic [255:0] in_b, out_r;
  logic [3:0]   fold_cnt;

  int n_chk = 0;
  int n_pass = 0;

  sm2_mod_reduce_seq #(.IN_W(512), .MAX_FOLDS(MAXF), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_err(out_err), .fold_cnt(fold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ref_mod(input logic [1:0] m, input logic [511:0] a,
                                           input logic [255:0] b);
    logic [513:0] t, pw;
    pw = {258'b0, P};
    case (m)
      2'b01:   t = {258'b0, a[255:0]} + {258'b0, b};
      2'b10:   t = {258'b0, a[255:0]} + (pw << 1) - {258'b0, b};
      default: t = {2'b0, a};
    endcase
    t = t % pw;
    return t[255:0];
  endfunction

  function automatic logic [511:0] r512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic start_job(input logic [1:0] m, input logic [511:0] a, input logic [255:0] b);
    @(negedge clk);
    in_mode = m; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts the accepting cycle as cycle 0; bounded so a dead DUT cannot hang the run.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 80) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [511:0] a, input logic [255:0] b,
                     output logic [255:0] r, output logic e, output int cnt, output int lat);
    start_job(m, a, b);
    wait_out(lat);
    r = out_r; e = out_err; cnt = int'(fold_cnt);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [1:0] m, input logic [511:0] a,
                     input logic [255:0] b, input logic [255:0] er, input int ecnt);
    logic [255:0] r; logic e; int cnt, lat;
    run(m, a, b, r, e, cnt, lat);
    chk({tag, "_r"}, r, er);
    chk({tag, "_err"}, 256'(e), 256'(0));
    chk({tag, "_bound"}, 256'(cnt <= MAXF), 256'(1));
    if (ecnt >= 0) chk({tag, "_cnt"}, 256'(cnt), 256'(CT ? MAXF : ecnt));
    chk({tag, "_lat"}, 256'(lat), 256'(CT ? 3 + MAXF : 3 + cnt));
  endtask

  initial begin
    logic [511:0] a, pm1sq, two256;
    logic [255:0] b, r, er;
    logic [1:0]   m;
    logic         e;
    int           cnt, lat;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_r", out_r, 256'(0));
    chk("rst_out_err", 256'(out_err), 256'(0));
    chk("rst_fold_cnt", 256'(fold_cnt), 256'(0));
    @(negedge clk) rst_n = 1'b1;

    two256 = '0; two256[256] = 1'b1;
    pm1sq = {256'b0, P - 256'd1} * {256'b0, P - 256'd1};
    dir("red_zero", 2'b00, 512'd0, 256'd0, 256'd0, 0);
    dir("red_2p256", 2'b00, two256, 256'd0, R256, 1);
    dir("red_p", 2'b00, {256'b0, P}, 256'd0, 256'd0, 0);
    dir("red_pm1sq", 2'b00, pm1sq, 256'd0, 256'd1, -1);
    dir("add_pm1_2", 2'b01, {256'b0, P - 256'd1}, 256'd2, 256'd1, 0);
    dir("sub_0_1", 2'b10, 512'd0, 256'd1, P - 256'd1, 1);
    dir("sub_5_5", 2'b10, 512'd5, 256'd5, 256'd0, 1);
    dir("add_max", 2'b01, {256'b0, {256{1'b1}}}, {256{1'b1}},
        ref_mod(2'b01, {256'b0, {256{1'b1}}}, {256{1'b1}}), -1);

    // Backpressure: result held, no accept while DONE, single transfer on release.
    a = r512();
    out_ready = 1'b0;
    start_job(2'b00, a, 256'd0);
    wait_out(lat);
    chk("bp_valid", 256'(out_valid), 256'(1));
    in_valid = 1'b1; in_a = r512(); in_mode = 2'b01;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_r", out_r, ref_mod(2'b00, a, 256'd0));
      chk("bp_hold_valid", 256'(out_valid), 256'(1));
      chk("bp_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_valid", 256'(out_valid), 256'(0));
    chk("bp_rel_ready", 256'(in_ready), 256'(1));
    dir("bp_next", 2'b00, two256, 256'd0, R256, 1);

    // Asynchronous reset in the middle of folding.
    a = r512(); a[511] = 1'b1;
    start_job(2'b00, a, 256'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    @(negedge clk) rst_n = 1'b1;
    dir("arst_next", 2'b00, two256, 256'd0, R256, 1);

    for (int i = 0; i < 1500; i++) begin
      m = 2'($urandom_range(0, 3));
      a = r512() >> $urandom_range(0, 300);
      b = r512()[255:0];
      er = ref_mod(m, a, b);
      run(m, a, b, r, e, cnt, lat);
      chk("rnd_r", r, er);
      chk("rnd_err", 256'(e), 256'(0));
      chk("rnd_lat", 256'(lat), 256'(CT ? 3 + MAXF : 3 + cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
